// File: rtl/dec_scan_seq.sv
// ============================================================================
// Module      : dec_scan_seq
// Description : Upstream sequencer for an sn74138 3-to-8 decoder. Walks the
//               select {C,B,A} through channels 0..7. Each channel gets a
//               blanking interval with the decoder disabled, followed by a
//               drive interval with the decoder enabled. Supports single-pass
//               or continuous scan with start/stop/done handshakes.
//               Optional channel skipping is compiled in by defining
//               DEC_SCAN_MASK_EN, which adds the chan_mask input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_scan_seq #(
    parameter int DWELL_CYCLES = 4,   // enabled cycles per channel, 1..255
    parameter int BLANK_CYCLES = 1    // disabled cycles before each channel, 1..255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       continuous,
`ifdef DEC_SCAN_MASK_EN
    input  logic [7:0] chan_mask,
`endif
    output logic       g1,
    output logic       g2a_n,
    output logic       g2b_n,
    output logic [2:0] sel,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Phase counter compares against the last cycle index of each interval.
    localparam logic [7:0] c_blank_last = 8'(BLANK_CYCLES - 1);
    localparam logic [7:0] c_dwell_last = 8'(DWELL_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_phase;
    logic [7:0] w_phase_nxt;
    logic [2:0] r_chan;
    logic [2:0] w_chan_nxt;
    logic       r_stop_pending;
    logic       w_stop_pending_nxt;
    logic       r_mode;
    logic       w_mode_nxt;
    logic       w_start_ok;

    // Channel masks: the one seen at start (for the first channel) and the
    // one latched for the rest of the scan. Without the mask feature both
    // are all-zero, so every channel is visited.
    logic [7:0] w_start_mask;
    logic [7:0] w_run_mask;

    logic       w_first_valid;
    logic [2:0] w_first_chan;
    logic [2:0] w_wrap_chan;
    logic       w_next_valid;
    logic [2:0] w_next_chan;
    logic       w_drive_nxt;
    logic       w_busy_nxt;

    assign w_start_ok = start && !stop;

`ifdef DEC_SCAN_MASK_EN
    logic [7:0] r_mask;

    assign w_start_mask = chan_mask;
    assign w_run_mask   = r_mask;

    // Mask is captured once, when a start is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= 8'h00;
        end else if (r_state == S_IDLE && w_start_ok) begin
            r_mask <= chan_mask;
        end
    end
`else
    localparam logic [7:0] c_no_mask = 8'h00;

    assign w_start_mask = c_no_mask;
    assign w_run_mask   = c_no_mask;
`endif

    // Channel search: lowest free channel of the start mask, lowest free
    // channel of the run mask (wrap target) and the next free channel above
    // the current one. Skipped channels therefore cost no cycles.
    always_comb begin
        w_first_valid = 1'b0;
        w_first_chan  = 3'd0;
        w_wrap_chan   = 3'd0;
        w_next_valid  = 1'b0;
        w_next_chan   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!w_start_mask[i]) begin
                w_first_valid = 1'b1;
                w_first_chan  = 3'(i);
            end
            if (!w_run_mask[i]) begin
                w_wrap_chan = 3'(i);
            end
            if (!w_run_mask[i] && (i > int'(r_chan))) begin
                w_next_valid = 1'b1;
                w_next_chan  = 3'(i);
            end
        end
    end

    // Next-state logic: interval timing, channel stepping and stop handling.
    always_comb begin
        w_state_nxt        = r_state;
        w_phase_nxt        = r_phase + 8'd1;
        w_chan_nxt         = r_chan;
        w_stop_pending_nxt = r_stop_pending;
        w_mode_nxt         = r_mode;

        case (r_state)
            S_IDLE: begin
                w_phase_nxt = 8'd0;
                if (w_start_ok) begin
                    w_mode_nxt = continuous;
                    if (w_first_valid) begin
                        w_state_nxt = S_BLANK;
                        w_chan_nxt  = w_first_chan;
                    end else begin
                        // Nothing to scan: finish immediately.
                        w_state_nxt = S_DONE;
                        w_chan_nxt  = 3'd0;
                    end
                end
            end

            S_BLANK: begin
                if (stop) begin
                    // Abort before the pending channel is ever enabled.
                    w_state_nxt = S_DONE;
                    w_phase_nxt = 8'd0;
                    w_chan_nxt  = 3'd0;
                end else if (r_phase == c_blank_last) begin
                    w_state_nxt = S_DRIVE;
                    w_phase_nxt = 8'd0;
                end
            end

            S_DRIVE: begin
                if (stop) begin
                    w_stop_pending_nxt = 1'b1;
                end
                if (r_phase == c_dwell_last) begin
                    w_phase_nxt = 8'd0;
                    if (r_stop_pending || stop) begin
                        // Dwell completed; honour the stop now.
                        w_state_nxt = S_DONE;
                        w_chan_nxt  = 3'd0;
                    end else if (w_next_valid) begin
                        w_state_nxt = S_BLANK;
                        w_chan_nxt  = w_next_chan;
                    end else if (r_mode) begin
                        w_state_nxt = S_BLANK;
                        w_chan_nxt  = w_wrap_chan;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_chan_nxt  = 3'd0;
                    end
                end
            end

            S_DONE: begin
                w_state_nxt        = S_IDLE;
                w_phase_nxt        = 8'd0;
                w_chan_nxt         = 3'd0;
                w_stop_pending_nxt = 1'b0;
            end

            default: begin
                w_state_nxt        = S_IDLE;
                w_phase_nxt        = 8'd0;
                w_chan_nxt         = 3'd0;
                w_stop_pending_nxt = 1'b0;
            end
        endcase
    end

    assign w_drive_nxt = (w_state_nxt == S_DRIVE);
    assign w_busy_nxt  = (w_state_nxt == S_BLANK) || (w_state_nxt == S_DRIVE);

    // State register and registered outputs, decoded from the next state so
    // the outputs line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_phase        <= 8'd0;
            r_chan         <= 3'd0;
            r_stop_pending <= 1'b0;
            r_mode         <= 1'b0;
            g1             <= 1'b0;
            g2a_n          <= 1'b1;
            g2b_n          <= 1'b1;
            sel            <= 3'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_phase        <= w_phase_nxt;
            r_chan         <= w_chan_nxt;
            r_stop_pending <= w_stop_pending_nxt;
            r_mode         <= w_mode_nxt;
            g1             <= w_drive_nxt;
            g2a_n          <= ~w_drive_nxt;
            g2b_n          <= ~w_drive_nxt;
            sel            <= w_chan_nxt;
            busy           <= w_busy_nxt;
            done           <= (w_state_nxt == S_DONE);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dec_scan_seq.sv
// ============================================================================
// Module      : tb_dec_scan_seq
// Description : Self-checking bench for dec_scan_seq. A position-based model
//               (cycles since start, modulo the channel period) predicts every
//               output each cycle; directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dec_scan_seq;

    localparam int DW = 4;
    localparam int BL = 1;
    localparam int P  = DW + BL;
    localparam logic [7:0] IDLE_VEC = 8'b0110_0000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       continuous = 1'b0;
    logic [7:0] mask = 8'h00;
    logic       g1, g2a_n, g2b_n, busy, done;
    logic [2:0] sel;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    dec_scan_seq #(
        .DWELL_CYCLES(DW),
        .BLANK_CYCLES(BL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .continuous(continuous),
`ifdef DEC_SCAN_MASK_EN
        .chan_mask (mask),
`endif
        .g1        (g1),
        .g2a_n     (g2a_n),
        .g2b_n     (g2b_n),
        .sel       (sel),
        .busy      (busy),
        .done      (done)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural model ----------------
    bit         m_active = 1'b0;
    int         m_p = 0;
    int         m_end = 0;
    int         m_n = 8;
    logic [7:0] m_maskl = 8'h00;

    function automatic int count_free(input logic [7:0] mk);
        int c = 0;
        for (int i = 0; i < 8; i++) if (!mk[i]) c++;
        return c;
    endfunction

    function automatic logic [2:0] chan_at(input logic [7:0] mk, input int k);
        int c = 0;
        for (int i = 0; i < 8; i++) begin
            if (!mk[i]) begin
                if (c == k) return 3'(i);
                c++;
            end
        end
        return 3'd0;
    endfunction

    always @(posedge clk) begin
        int e;
        if (reset) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (start && !stop) begin
                m_active = 1'b1;
                m_p      = 0;
                m_maskl  = mask;
                m_n      = count_free(mask);
                if (m_n == 0)       m_end = 0;
                else if (continuous) m_end = 32'h7fff_ffff;
                else                m_end = m_n * P;
            end
        end else if (m_p == m_end) begin
            m_active = 1'b0;
        end else begin
            if (stop) begin
                if ((m_p % P) < BL) e = m_p + 1;
                else                e = (m_p / P + 1) * P;
                if (e < m_end) m_end = e;
            end
            m_p++;
        end
    end

    function automatic logic [7:0] exp_vec();
        bit en;
        logic [2:0] ch;
        if (!m_active) return IDLE_VEC;
        if (m_p == m_end) return 8'b0110_0001;
        en = ((m_p % P) >= BL);
        ch = chan_at(m_maskl, (m_p / P) % m_n);
        return {en, !en, !en, ch, 1'b1, 1'b0};
    endfunction

    // ---------------- compare process ----------------
    int         en_per[8];
    logic       prev_g1 = 1'b0;
    logic [2:0] prev_sel = 3'd0;

    initial for (int i = 0; i < 8; i++) en_per[i] = 0;

    always @(negedge clk) begin
        logic [7:0] act, ex;
        if (chk_en) begin
            act = {g1, g2a_n, g2b_n, sel, busy, done};
            ex  = exp_vec();
            n_cmp++;
            if (act !== ex) begin
                n_bad++;
                $display("FAIL outputs @cyc %0d: got %b want %b ({g1,g2a_n,g2b_n,sel,busy,done})",
                         cyc, act, ex);
            end
            if (g1 === 1'b1 && prev_g1 === 1'b1) begin
                n_cmp++;
                if (sel !== prev_sel) begin
                    n_bad++;
                    $display("FAIL sel_stable @cyc %0d: got %0d want %0d", cyc, sel, prev_sel);
                end
            end
            if (g1 === 1'b1) en_per[sel] = en_per[sel] + 1;
            prev_g1  = g1;
            prev_sel = sel;
        end
    end

    // ---------------- stimulus helpers ----------------
    int base_per[8];
    int e0 = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic check_vec(input string nm, input logic [7:0] want);
        logic [7:0] act;
        act = {g1, g2a_n, g2b_n, sel, busy, done};
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", nm, act, want);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 8; i++) base_per[i] = en_per[i];
    endtask

    function automatic int en_total();
        int s = 0;
        for (int i = 0; i < 8; i++) s += en_per[i] - base_per[i];
        return s;
    endfunction

    function automatic int en_chans();
        int m = 0;
        for (int i = 0; i < 8; i++) if (en_per[i] > base_per[i]) m |= (1 << i);
        return m;
    endfunction

    // Leaves the bench at the negedge just after the accepting edge e0.
    task automatic pulse_start(input logic cont);
        snap();
        continuous = cont;
        start      = 1'b1;
        e0         = cyc + 1;
        @(negedge clk);
        start      = 1'b0;
        continuous = 1'b0;
    endtask

    // Returns the number of edges from e0 to the edge that raised done.
    task automatic wait_done(input int max, input string nm, output int lat);
        int k = 0;
        while (done !== 1'b1 && k < max) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: done not seen within %0d cycles", nm, max);
        end
        lat = cyc - e0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int lat;

        // 1. reset and idle
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_vec("reset_values", IDLE_VEC);
        stop = 1'b1;
        tick(2);
        check_vec("idle_stop_ignored", IDLE_VEC);
        start = 1'b1;
        tick(2);
        start = 1'b0;
        stop  = 1'b0;
        check_vec("idle_start_stop", IDLE_VEC);
        tick(1);

        // 2. single pass
        pulse_start(1'b0);
        check_vec("first_blank_ch0", 8'b0110_0010);
        tick(1);
        check_vec("first_drive_ch0", 8'b1000_0010);
        wait_done(60, "single_pass", lat);
        check_int("single_done_latency", lat, 40);
        tick(1);
        check_int("single_enabled_cycles", en_total(), 32);
        check_int("single_channels", en_chans(), 8'hFF);
        check_vec("single_back_idle", IDLE_VEC);
        tick(2);

        // 3. continuous, stop in 2nd drive cycle of channel 2 on second lap
        pulse_start(1'b1);
        tick(40);
        check_vec("wrap_blank_ch0", 8'b0110_0010);
        tick(12);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        wait_done(20, "cont_stop", lat);
        check_int("cont_done_latency", lat, 55);
        tick(1);
        check_int("cont_enabled_cycles", en_total(), 44);
        tick(2);

        // 4. stop during blank of channel 5, start during scan ignored
        pulse_start(1'b0);
        tick(10);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(14);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        wait_done(10, "blank_stop", lat);
        check_int("blank_stop_latency", lat, 26);
        tick(1);
        check_int("blank_stop_channels", en_chans(), 8'h1F);
        check_int("blank_stop_enabled", en_total(), 20);
        tick(2);

        // 5. reset mid-scan in channel 3 drive, then a clean pass
        pulse_start(1'b0);
        tick(17);
        reset = 1'b1;
        tick(1);
        check_vec("reset_mid_scan", IDLE_VEC);
        tick(1);
        reset = 1'b0;
        check_vec("reset_no_done", IDLE_VEC);
        tick(2);
        pulse_start(1'b0);
        wait_done(60, "after_reset_pass", lat);
        check_int("after_reset_latency", lat, 40);
        tick(1);
        check_int("after_reset_enabled", en_total(), 32);
        tick(2);

`ifdef DEC_SCAN_MASK_EN
        // 6. channel mask
        mask = 8'hA5;
        pulse_start(1'b0);
        wait_done(40, "mask_a5", lat);
        check_int("mask_a5_latency", lat, 20);
        tick(1);
        check_int("mask_a5_channels", en_chans(), 8'h5A);
        tick(2);
        mask = 8'hFF;
        pulse_start(1'b0);
        wait_done(5, "mask_ff", lat);
        check_int("mask_ff_latency", lat, 0);
        tick(1);
        check_int("mask_ff_enabled", en_total(), 0);
        mask = 8'h00;
        tick(2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
